cnn_result_collector: RTL

- Sits directly downstream of crop_plus_gaussian.
- Consumes its five independent single-word CNN output streams (cnn_output_0..4) and captures one word per stream per frame, in whatever order and skew they arrive.
- Re-emits the five words as one ordered AXI-stream packet with TLAST, plus a frame-done pulse and a frame counter.
- Gives the DMA/host side a single stream and a single completion event per frame.

---
 rtl/cnn_result_collector.sv | 113 +++++++++++
 1 files changed

// File: rtl/cnn_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : cnn_result_collector
// Brief    : Captures one word from each of NUM_OUTPUTS independent CNN output
//            streams per frame, in any order or skew. Re-emits them as one
//            ordered AXI-stream packet with TLAST, a frame-done pulse and a
//            wrapping frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_result_collector #(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int NUM_OUTPUTS     = 5,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst_n,
  input  logic [NUM_OUTPUTS*PIXEL_BIT_WIDTH-1:0] cnn_output_TDATA,
  input  logic [NUM_OUTPUTS-1:0]                 cnn_output_TVALID,
  output logic [NUM_OUTPUTS-1:0]                 cnn_output_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]             result_TDATA,
  output logic                                   result_TVALID,
  input  logic                                   result_TREADY,
  output logic                                   result_TLAST,
  output logic                                   frame_done,
  output logic [FRAME_CNT_WIDTH-1:0]             frame_count
);

  localparam int                 c_IDX_W    = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_OUTPUTS - 1);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_EMIT    = 1'b1
  } state_t;

  state_t                     r_state;
  logic [NUM_OUTPUTS-1:0]     r_captured;
  logic [PIXEL_BIT_WIDTH-1:0] r_buf [NUM_OUTPUTS];
  logic [c_IDX_W-1:0]         r_idx;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
  logic                       r_frame_done;

  logic                       w_collect;
  logic                       w_emit;
  logic [NUM_OUTPUTS-1:0]     w_capture;
  logic [NUM_OUTPUTS-1:0]     w_captured_nxt;
  logic                       w_last;

  assign w_collect = (r_state == S_COLLECT);
  assign w_emit    = (r_state == S_EMIT);
  assign w_last    = (r_idx == c_LAST_IDX);

  // Uncaptured channels are ready while collecting; held off during reset so
  // nothing upstream is consumed before the block is running.
  assign cnn_output_TREADY = (w_collect && ap_rst_n) ? ~r_captured : '0;

  assign w_capture      = cnn_output_TVALID & cnn_output_TREADY;
  assign w_captured_nxt = r_captured | w_capture;

  // Output side is decoded purely from registers, so it cannot move while stalled.
  assign result_TVALID = w_emit;
  assign result_TLAST  = w_emit && w_last;
  assign result_TDATA  = w_emit ? r_buf[r_idx] : '0;
  assign frame_done    = r_frame_done;
  assign frame_count   = r_frame_count;

  // Collect/emit sequencer: captures per-channel words, then walks them out in channel order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= S_COLLECT;
      r_captured    <= '0;
      r_idx         <= '0;
      r_frame_count <= '0;
      r_frame_done  <= 1'b0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        r_buf[k] <= '0;
      end
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (w_capture[k]) begin
              r_buf[k] <= cnn_output_TDATA[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
            end
          end
          r_captured <= w_captured_nxt;
          if (&w_captured_nxt) begin
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (result_TREADY) begin
            if (w_last) begin
              r_idx         <= '0;
              r_captured    <= '0;
              r_state       <= S_COLLECT;
              r_frame_count <= r_frame_count + 1'b1;
              r_frame_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_COLLECT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
